nor_multi_ctrl: RTL and testbench
=================================

Name: nor_multi_ctrl

Overview:
Parametrised multi-device parallel NOR controller. It is the next-generation replacement for the single-device NOR back end behind the QSPI control FSM's memory wishbone. It decodes upper wishbone address bits into one of NCHIPS chip-enables, which share address, data, WE and OE. Access timing is programmable, each device's RY/BY# is synchronised, and busy devices are waited on with a timeout that reports a wishbone error.

Parameters:
ADDRBITS, 26, NOR word-address width per device
DATABITS, 16, NOR data width
NCHIPS, 4, number of NOR devices (1..16); CSBITS = max(1, clog2(NCHIPS)) is a localparam
TSETUP, 2, cycles with address and CE# valid before OE#/WE# falls (>=1)
TRD, 8, cycles OE# held low on a read; data sampled on the last cycle (>=1)
TWP, 4, cycles WE# held low on a write (>=1)
THOLD, 2, cycles address, data and CE# held after WE# rises (>=1)
TOBITS, 20, width of the RY wait timeout counter; timeout = 2^TOBITS-1 cycles

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
wb_cyc_i  in  1  wishbone cycle
wb_stb_i  in  1  wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  CSBITS+ADDRBITS  {chip index, word address}
wb_dat_i  in  DATABITS  write data
wb_dat_o  out  DATABITS  read data, valid with ack
wb_ack_o  out  1  single-cycle acknowledge
wb_err_o  out  1  single-cycle error
wb_stall_o  out  1  high while a transaction is in flight
nor_ry_i  in  NCHIPS  per-device RY/BY#, asynchronous, 1 = ready
nor_data_i  in  DATABITS  NOR data in
nor_data_o  out  DATABITS  NOR data out
nor_addr_o  out  ADDRBITS  NOR address
nor_ce_o  out  NCHIPS  CE#, active low, one-hot-low
nor_we_o  out  1  WE#, active low
nor_oe_o  out  1  OE#, active low
nor_data_oe  out  1  1 = drive nor_data_o
busy_o  out  1  any synchronised RY low

Behaviour:
- Clocking and reset: single clock clk_i; reset_i is synchronous and active-high.
- Reset values: nor_ce_o all 1; nor_we_o=1; nor_oe_o=1; nor_data_oe=0; nor_addr_o=0; nor_data_o=0; wb_ack_o=0; wb_err_o=0; wb_stall_o=1 while reset_i is high; wb_dat_o=0; RY synchronisers=all 1; FSM=IDLE.
- Reset mid-operation: reset returns all outputs to these values on the next edge. The in-flight transaction is dropped with no ack.
- RY synchronisation: 2-flop synchroniser per bit. busy_o = |~ry_sync (registered).
- Acceptance: a request is accepted when wb_cyc_i & wb_stb_i & ~wb_stall_o. wb_stall_o = (state != IDLE). One transaction is outstanding at a time.
- Latching: address, data, we and chip index are latched on acceptance.
- Illegal chip: chip index >= NCHIPS -> wb_err_o pulses on the cycle after acceptance. No NOR pins toggle.
- State IDLE -> WAIT_RY on acceptance of a legal index.
- State WAIT_RY: nor_ce_o stays all high.
  - Leaves to SETUP in the cycle ry_sync[idx]=1 is seen; this takes 1 cycle if already ready.
  - Timeout counter reaching all-ones -> ERR (wb_err_o 1 cycle) -> IDLE.
- State SETUP (TSETUP cycles): nor_addr_o valid, nor_ce_o[idx]=0, WE#/OE# high.
  - nor_data_oe=1 and nor_data_o driven for writes from the first SETUP cycle.
- State ACCESS, read: TRD cycles, OE#=0. nor_data_i is registered on the final cycle -> RACK.
- State ACCESS, write: TWP cycles, WE#=0 -> HOLD.
- State HOLD (THOLD cycles): WE# high; CE#, address and data held -> RACK.
- State RACK: CE# high, nor_data_oe=0, wb_ack_o=1 for exactly 1 cycle, wb_dat_o valid (reads) -> IDLE.
- Read latency: acceptance edge E0 -> ack high in cycle E0+1+TSETUP+TRD+1 when the device is ready.
- Write latency: acceptance edge E0 -> ack in cycle E0+1+TSETUP+TWP+THOLD+1.
- wb_cyc_i dropped in WAIT_RY or SETUP: return to IDLE next cycle, CE# released, no ack or err.
- wb_cyc_i dropped in ACCESS or HOLD: the NOR timing runs to completion so WE# pulse integrity is kept. Ack is suppressed.
- Glitch rules: OE# and WE# are never low simultaneously. Only one CE# is low at any time. nor_data_oe=0 whenever OE#=0.
- Counters: one shared down-counter sized clog2(max(TSETUP,TRD,TWP,THOLD)+1). The timeout counter is TOBITS wide and cleared on entry to WAIT_RY.

Decomposition:
- Shared package/header (alongside the bus map defines):
  - state encoding localparams;
  - CLOG2 macro;
  - default timing constants, so the QSPI control FSM and the bench share them.
- Sub-module nor_ry_sync: parametrised NCHIPS-wide 2-flop synchroniser with reset-to-1.
- FSM, counters and pin registers stay in nor_multi_ctrl.

Test Plan:
- Read chip 2, addr 0x012345, nor_data_i=0xBEEF, all RY=1, defaults -> nor_ce_o=4'b1011 from E0+2, OE# low 8 cycles, ack at E0+12, wb_dat_o=0xBEEF.
- Write chip 0, addr 0x3FFFFFF (max), data 0xA5A5 -> WE# low exactly 4 cycles, data_oe=1 throughout SETUP/ACCESS/HOLD, ack at E0+10.
- RY[1]=0 for 50 cycles then 1, read chip 1 -> CE# stays high until 2 cycles after RY rises (sync), then normal read timing and ack.
- TOBITS=4, RY[3] stuck 0, access chip 3 -> wb_err_o pulse after 15 WAIT_RY cycles, no CE# toggling, stall drops.
- NCHIPS=3, access index 3 -> err at E0+1, no NOR activity. Then a back-to-back read of chip 0 is accepted in the next cycle.
- reset_i asserted mid-write ACCESS -> next edge WE#=1, CE#=all 1, data_oe=0, no ack. wb_cyc_i dropped during SETUP -> IDLE, no ack.

Source files
------------

// File: rtl/nor_multi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nor_multi_ctrl_pkg
// Brief   : Shared FSM encodings, default NOR timing and helper functions
//           for the multi-device parallel NOR controller and its users.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef NOR_CLOG2
`define NOR_CLOG2(x) ($clog2(x))
`endif

package nor_multi_ctrl_pkg;

  // Controller state encoding (kept as plain constants for legacy users)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_RY = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_ACCESS  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RACK    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  // Default geometry and timing, shared with the QSPI control FSM
  localparam int NOR_ADDRBITS_DEF = 26;
  localparam int NOR_DATABITS_DEF = 16;
  localparam int NOR_NCHIPS_DEF   = 4;
  localparam int NOR_TSETUP_DEF   = 2;
  localparam int NOR_TRD_DEF      = 8;
  localparam int NOR_TWP_DEF      = 4;
  localparam int NOR_THOLD_DEF    = 2;
  localparam int NOR_TOBITS_DEF   = 20;

  // Largest of the four phase lengths; sizes the shared phase counter
  function automatic int nor_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Chip-select field width; never narrower than one bit
  function automatic int nor_csbits(input int n);
    return (n > 1) ? `NOR_CLOG2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nor_multi_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : nor_multi_ctrl_if
// Brief   : Pipelined wishbone slave port of the NOR controller. Signal
//           suffixes are written from the controller's point of view.
// Revision: 1.0 - initial release
// ============================================================================
interface nor_multi_ctrl_if #(
  parameter int AW = 28,
  parameter int DW = 16
);
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
endinterface
`default_nettype wire

// File: rtl/nor_ry_sync.sv
`default_nettype none
// ============================================================================
// Module  : nor_ry_sync
// Brief   : NCHIPS-wide two-flop synchroniser for the asynchronous RY/BY#
//           pins. Resets to "ready" so no device looks busy out of reset.
// Revision: 1.0 - initial release
// ============================================================================
module nor_ry_sync #(
  parameter int NCHIPS = 4
) (
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  input  wire logic [NCHIPS-1:0] ry_i,
  output logic      [NCHIPS-1:0] ry_sync_o
);

  logic [NCHIPS-1:0] meta_q;
  logic [NCHIPS-1:0] sync_q;

  // Two register stages per bit to resolve metastability
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= ry_i;
      sync_q <= meta_q;
    end
  end

  assign ry_sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/nor_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nor_multi_ctrl
// Brief   : Multi-device parallel NOR controller. Upper wishbone address bits
//           select one of NCHIPS chip-enables; address, data, WE# and OE# are
//           shared. Phase timing is programmable and busy devices are waited
//           on with a timeout that reports a wishbone error.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef NOR_CLOG2
`define NOR_CLOG2(x) ($clog2(x))
`endif

module nor_multi_ctrl
  import nor_multi_ctrl_pkg::*;
#(
  parameter int ADDRBITS = NOR_ADDRBITS_DEF,
  parameter int DATABITS = NOR_DATABITS_DEF,
  parameter int NCHIPS   = NOR_NCHIPS_DEF,
  parameter int TSETUP   = NOR_TSETUP_DEF,
  parameter int TRD      = NOR_TRD_DEF,
  parameter int TWP      = NOR_TWP_DEF,
  parameter int THOLD    = NOR_THOLD_DEF,
  parameter int TOBITS   = NOR_TOBITS_DEF
) (
  input  wire logic                clk_i,
  input  wire logic                reset_i,
  nor_multi_ctrl_if.slave          wb,
  input  wire logic [NCHIPS-1:0]   nor_ry_i,
  input  wire logic [DATABITS-1:0] nor_data_i,
  output logic      [DATABITS-1:0] nor_data_o,
  output logic      [ADDRBITS-1:0] nor_addr_o,
  output logic      [NCHIPS-1:0]   nor_ce_o,
  output logic                     nor_we_o,
  output logic                     nor_oe_o,
  output logic                     nor_data_oe,
  output logic                     busy_o
);

  localparam int CSBITS = nor_csbits(NCHIPS);
  localparam int CSPAD  = 1 << CSBITS;
  localparam int CNTW   = `NOR_CLOG2(nor_max4(TSETUP, TRD, TWP, THOLD) + 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [NCHIPS-1:0]   w_ry_sync;
  logic [CSPAD-1:0]    w_ry_pad;
  logic [CSPAD-1:0]    w_legal_vec;
  logic [CSBITS-1:0]   w_idx;
  logic                w_stall;
  logic                w_req;
  logic                w_illegal;
  logic                w_active;
  logic [TOBITS-1:0]   w_to_inc;

  logic [2:0]          state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [TOBITS-1:0]   to_q, to_d;
  logic                abort_q, abort_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic                we_q, we_d;
  logic [CSBITS-1:0]   idx_q, idx_d;
  logic [DATABITS-1:0] rdat_q, rdat_d;

  logic [NCHIPS-1:0]   ce_q, ce_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                doe_q, doe_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] dout_q, dout_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q;

  // --------------------------------------------------------------------------
  // RY/BY# synchroniser
  // --------------------------------------------------------------------------
  nor_ry_sync #(.NCHIPS(NCHIPS)) u_ry_sync (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ry_i      (nor_ry_i),
    .ry_sync_o (w_ry_sync)
  );

  // Request decode; stall also covers reset so nothing is accepted then
  assign w_stall = reset_i | (state_q != ST_IDLE);
  assign w_req   = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall;
  assign w_idx   = wb.wb_adr_i[CSBITS+ADDRBITS-1 -: CSBITS];

  // Pad per-chip vectors to the full index range so unused indices read 0
  always_comb begin
    w_ry_pad               = '0;
    w_ry_pad[NCHIPS-1:0]   = w_ry_sync;
    w_legal_vec            = '0;
    for (int i = 0; i < CSPAD; i++) begin
      w_legal_vec[i] = (i < NCHIPS);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: FSM, shared phase counter, timeout and latches
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    abort_d   = abort_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    idx_d     = idx_q;
    rdat_d    = rdat_q;
    w_illegal = 1'b0;
    w_to_inc  = to_q + TOBITS'(1);

    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          adr_d = wb.wb_adr_i[ADDRBITS-1:0];
          dat_d = wb.wb_dat_i;
          we_d  = wb.wb_we_i;
          idx_d = w_idx;
          if (w_legal_vec[w_idx]) begin
            state_d = ST_WAIT_RY;
            to_d    = '0;
            abort_d = 1'b0;
          end else begin
            // Nonexistent device: answer with an error, pins stay idle
            w_illegal = 1'b1;
          end
        end
      end

      ST_WAIT_RY: begin
        if (!wb.wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (w_ry_pad[idx_q]) begin
          state_d = ST_SETUP;
          cnt_d   = CNTW'(TSETUP - 1);
        end else begin
          to_d = w_to_inc;
          if (&w_to_inc) begin
            state_d = ST_ERR;
          end
        end
      end

      ST_SETUP: begin
        if (!wb.wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = we_q ? CNTW'(TWP - 1) : CNTW'(TRD - 1);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      ST_ACCESS: begin
        // Once OE#/WE# has fallen the pulse is always completed
        if (!wb.wb_cyc_i) begin
          abort_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if (we_q) begin
            state_d = ST_HOLD;
            cnt_d   = CNTW'(THOLD - 1);
          end else begin
            state_d = ST_RACK;
            rdat_d  = nor_data_i;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      ST_HOLD: begin
        if (!wb.wb_cyc_i) begin
          abort_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = ST_RACK;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      ST_RACK: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values derived from the next state so every pin is a clean flop
  always_comb begin
    w_active = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
    ce_d     = '1;
    for (int i = 0; i < NCHIPS; i++) begin
      if (w_active && (idx_d == CSBITS'(i))) begin
        ce_d[i] = 1'b0;
      end
    end
    oe_n_d = ~((state_d == ST_ACCESS) && !we_d);
    we_n_d = ~((state_d == ST_ACCESS) && we_d);
    doe_d  = w_active && we_d;
    addr_d = w_active ? adr_d : addr_q;
    dout_d = (w_active && we_d) ? dat_d : dout_q;
    ack_d  = (state_d == ST_RACK) && !abort_d;
    err_d  = (state_d == ST_ERR) || w_illegal;
  end

  // --------------------------------------------------------------------------
  // State, counter and latch registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      abort_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      abort_q <= abort_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      rdat_q  <= rdat_d;
    end
  end

  // Output pin and bus response registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ce_q   <= '1;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      doe_q  <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      doe_q  <= doe_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      busy_q <= |(~w_ry_sync);
    end
  end

  assign nor_ce_o      = ce_q;
  assign nor_we_o      = we_n_q;
  assign nor_oe_o      = oe_n_q;
  assign nor_data_oe   = doe_q;
  assign nor_addr_o    = addr_q;
  assign nor_data_o    = dout_q;
  assign busy_o        = busy_q;
  assign wb.wb_dat_o   = rdat_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_stall_o = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_nor_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_nor_multi_ctrl
// Brief   : Directed self-checking bench for nor_multi_ctrl. Three instances
//           (defaults, short timeout, three devices) share one stimulus set;
//           sel chooses which one receives the wishbone cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nor_multi_ctrl;
  import nor_multi_ctrl_pkg::*;

  localparam int AB  = 26;
  localparam int DB  = 16;
  localparam int CSB = 2;
  localparam int AW  = CSB + AB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0] adr  = '0;
  logic [DB-1:0] wdat = '0, ndat = '0;
  logic [3:0]    ry_a = '1, ry_b = '1;
  logic [2:0]    ry_c = '1;
  int            sel  = 0;

  nor_multi_ctrl_if #(.AW(AW), .DW(DB)) ifa ();
  nor_multi_ctrl_if #(.AW(AW), .DW(DB)) ifb ();
  nor_multi_ctrl_if #(.AW(AW), .DW(DB)) ifc ();

  assign ifa.wb_cyc_i = cyc & (sel == 0);
  assign ifa.wb_stb_i = stb & (sel == 0);
  assign ifa.wb_we_i  = we;
  assign ifa.wb_adr_i = adr;
  assign ifa.wb_dat_i = wdat;
  assign ifb.wb_cyc_i = cyc & (sel == 1);
  assign ifb.wb_stb_i = stb & (sel == 1);
  assign ifb.wb_we_i  = we;
  assign ifb.wb_adr_i = adr;
  assign ifb.wb_dat_i = wdat;
  assign ifc.wb_cyc_i = cyc & (sel == 2);
  assign ifc.wb_stb_i = stb & (sel == 2);
  assign ifc.wb_we_i  = we;
  assign ifc.wb_adr_i = adr;
  assign ifc.wb_dat_i = wdat;

  logic [DB-1:0] dout_a, dout_b, dout_c;
  logic [AB-1:0] addr_a, addr_b, addr_c;
  logic [3:0]    ce_a, ce_b;
  logic [2:0]    ce_c;
  logic          we_a, we_b, we_c, oe_a, oe_b, oe_c;
  logic          doe_a, doe_b, doe_c, busy_a, busy_b, busy_c;

  nor_multi_ctrl dut_a (
    .clk_i(clk), .reset_i(reset), .wb(ifa), .nor_ry_i(ry_a), .nor_data_i(ndat),
    .nor_data_o(dout_a), .nor_addr_o(addr_a), .nor_ce_o(ce_a), .nor_we_o(we_a),
    .nor_oe_o(oe_a), .nor_data_oe(doe_a), .busy_o(busy_a)
  );

  nor_multi_ctrl #(.TOBITS(4)) dut_b (
    .clk_i(clk), .reset_i(reset), .wb(ifb), .nor_ry_i(ry_b), .nor_data_i(ndat),
    .nor_data_o(dout_b), .nor_addr_o(addr_b), .nor_ce_o(ce_b), .nor_we_o(we_b),
    .nor_oe_o(oe_b), .nor_data_oe(doe_b), .busy_o(busy_b)
  );

  nor_multi_ctrl #(.NCHIPS(3)) dut_c (
    .clk_i(clk), .reset_i(reset), .wb(ifc), .nor_ry_i(ry_c), .nor_data_i(ndat),
    .nor_data_o(dout_c), .nor_addr_o(addr_c), .nor_ce_o(ce_c), .nor_we_o(we_c),
    .nor_oe_o(oe_c), .nor_data_oe(doe_c), .busy_o(busy_c)
  );

  // Observed signals of the selected instance
  logic          m_ack, m_err, m_stall, m_we, m_oe, m_doe, m_busy;
  logic [DB-1:0] m_dat, m_dout;
  logic [AB-1:0] m_addr;
  logic [3:0]    m_ce;

  always_comb begin
    m_ack = ifa.wb_ack_o; m_err = ifa.wb_err_o; m_stall = ifa.wb_stall_o; m_dat = ifa.wb_dat_o;
    m_ce = ce_a; m_we = we_a; m_oe = oe_a; m_doe = doe_a; m_addr = addr_a; m_dout = dout_a; m_busy = busy_a;
    if (sel == 1) begin
      m_ack = ifb.wb_ack_o; m_err = ifb.wb_err_o; m_stall = ifb.wb_stall_o; m_dat = ifb.wb_dat_o;
      m_ce = ce_b; m_we = we_b; m_oe = oe_b; m_doe = doe_b; m_addr = addr_b; m_dout = dout_b; m_busy = busy_b;
    end else if (sel == 2) begin
      m_ack = ifc.wb_ack_o; m_err = ifc.wb_err_o; m_stall = ifc.wb_stall_o; m_dat = ifc.wb_dat_o;
      m_ce = {1'b1, ce_c}; m_we = we_c; m_oe = oe_c; m_doe = doe_c; m_addr = addr_c; m_dout = dout_c; m_busy = busy_c;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-transfer observations; n counts edges after the acceptance edge E0
  int            ack_n, err_n, ce_first, ce_low, oe_low, we_low, doe_cnt, ack_cnt, err_cnt, glitch;
  logic [3:0]    ce_val;
  logic [AB-1:0] addr_val;
  logic [DB-1:0] dat_val, dout_val;
  logic          stall_end;

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DB-1:0] d,
                      input int ncyc, input int drop_n, input int ry_n, input int ry_bit,
                      input logic b2b, input logic [AW-1:0] a2);
    ack_n = -1; err_n = -1; ce_first = -1; ce_low = 0; oe_low = 0; we_low = 0;
    doe_cnt = 0; ack_cnt = 0; err_cnt = 0; glitch = 0;
    ce_val = '1; addr_val = '0; dat_val = '0; dout_val = '0;
    we = w; adr = a; wdat = d; cyc = 1'b1; stb = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (n == 0 && !b2b) stb = 1'b0;
      if (n == 1) stb = 1'b0;
      if (m_ack) begin
        ack_cnt++;
        if (ack_n < 0) begin ack_n = n; dat_val = m_dat; end
      end
      if (m_err) begin
        err_cnt++;
        if (err_n < 0) err_n = n;
      end
      if (m_ce != 4'hF) begin
        ce_low++;
        if (ce_first < 0) begin ce_first = n; ce_val = m_ce; addr_val = m_addr; end
      end
      if (!m_oe) oe_low++;
      if (!m_we) we_low++;
      if (m_doe) begin doe_cnt++; dout_val = m_dout; end
      if (!m_oe && !m_we) glitch++;
      if (m_doe && !m_oe) glitch++;
      if ($countones(~m_ce) > 1) glitch++;
      if (m_ack || (m_err && !(b2b && n == 0))) cyc = 1'b0;
      if (n == drop_n) cyc = 1'b0;
      if (n == ry_n) ry_a[ry_bit] = 1'b1;
      if (b2b && n == 0) begin adr = a2; we = 1'b0; end
    end
    cyc = 1'b0;
    stb = 1'b0;
    stall_end = m_stall;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_stall", m_stall, 1'b1);
    check("rst_ce", m_ce, 4'hF);
    check("rst_we", m_we, 1'b1);
    check("rst_oe", m_oe, 1'b1);
    check("rst_doe", m_doe, 1'b0);
    check("rst_ack_err", {m_ack, m_err}, 2'b00);
    check("rst_addr_dout", {m_addr, m_dout, m_dat}, '0);
    check("rst_busy", m_busy, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_stall", m_stall, 1'b0);

    // Read chip 2 on the default instance
    ndat = 16'hBEEF;
    xfer(1'b0, {2'd2, 26'h0012345}, 16'h0, 16, -1, -1, 0, 1'b0, '0);
    check("rd_ack_n", ack_n, 11);
    check("rd_ce_first", ce_first, 1);
    check("rd_ce_val", ce_val, 4'b1011);
    check("rd_addr", addr_val, 26'h0012345);
    check("rd_oe_low", oe_low, 8);
    check("rd_we_low", we_low, 0);
    check("rd_doe", doe_cnt, 0);
    check("rd_data", dat_val, 16'hBEEF);
    check("rd_ack_cnt", ack_cnt, 1);
    check("rd_err_cnt", err_cnt, 0);
    check("rd_glitch", glitch, 0);
    check("rd_stall_end", stall_end, 1'b0);

    // Write chip 0 at the top word address
    xfer(1'b1, {2'd0, 26'h3FFFFFF}, 16'hA5A5, 14, -1, -1, 0, 1'b0, '0);
    check("wr_ack_n", ack_n, 9);
    check("wr_we_low", we_low, 4);
    check("wr_oe_low", oe_low, 0);
    check("wr_doe_cnt", doe_cnt, 8);
    check("wr_ce_low", ce_low, 8);
    check("wr_ce_val", ce_val, 4'b1110);
    check("wr_addr", addr_val, 26'h3FFFFFF);
    check("wr_dout", dout_val, 16'hA5A5);
    check("wr_ack_cnt", ack_cnt, 1);
    check("wr_glitch", glitch, 0);

    // Chip 1 busy: CE# held off until the synchronised RY rises
    ry_a[1] = 1'b0;
    repeat (3) tick();
    check("ry_busy", m_busy, 1'b1);
    ndat = 16'h5A3C;
    xfer(1'b0, {2'd1, 26'h0000ABC}, 16'h0, 70, -1, 49, 1, 1'b0, '0);
    check("ry_ce_first", ce_first, 52);
    check("ry_ce_val", ce_val, 4'b1101);
    check("ry_ack_n", ack_n, 62);
    check("ry_data", dat_val, 16'h5A3C);
    check("ry_busy_end", m_busy, 1'b0);

    // Short-timeout instance, chip 3 stuck busy
    sel = 1;
    ry_b[3] = 1'b0;
    repeat (3) tick();
    xfer(1'b0, {2'd3, 26'h0000010}, 16'h0, 20, -1, -1, 0, 1'b0, '0);
    check("to_err_n", err_n, 15);
    check("to_err_cnt", err_cnt, 1);
    check("to_ce_low", ce_low, 0);
    check("to_ack_cnt", ack_cnt, 0);
    check("to_stall_end", stall_end, 1'b0);
    ry_b[3] = 1'b1;

    // Three-device instance: illegal index 3, then back-to-back read of chip 0
    sel = 2;
    ndat = 16'h1234;
    xfer(1'b0, {2'd3, 26'h0000055}, 16'h0, 18, -1, -1, 0, 1'b1, {2'd0, 26'h0000077});
    check("ill_err_n", err_n, 0);
    check("ill_err_cnt", err_cnt, 1);
    check("b2b_ce_first", ce_first, 2);
    check("b2b_ce_val", ce_val, 4'b1110);
    check("b2b_addr", addr_val, 26'h0000077);
    check("b2b_ack_n", ack_n, 12);
    check("b2b_data", dat_val, 16'h1234);

    // Reset during write ACCESS on the default instance
    sel = 0;
    we = 1'b1; adr = {2'd1, 26'h0000100}; wdat = 16'h3C3C; cyc = 1'b1; stb = 1'b1;
    tick();
    stb = 1'b0;
    repeat (3) tick();
    check("mr_we_before", m_we, 1'b0);
    reset = 1'b1;
    tick();
    check("mr_we", m_we, 1'b1);
    check("mr_ce", m_ce, 4'hF);
    check("mr_doe", m_doe, 1'b0);
    check("mr_stall", m_stall, 1'b1);
    reset = 1'b0;
    cyc = 1'b0;
    ack_cnt = 0;
    if (m_ack) ack_cnt++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m_ack) ack_cnt++;
    end
    check("mr_no_ack", ack_cnt, 0);

    // Cycle dropped during SETUP
    xfer(1'b0, {2'd2, 26'h0000200}, 16'h0, 16, 1, -1, 0, 1'b0, '0);
    check("drop_setup_ce_low", ce_low, 1);
    check("drop_setup_ack", ack_cnt + err_cnt, 0);
    check("drop_setup_stall", stall_end, 1'b0);

    // Cycle dropped during write ACCESS: pulse completes, ack suppressed
    xfer(1'b1, {2'd3, 26'h0000300}, 16'h0F0F, 16, 4, -1, 0, 1'b0, '0);
    check("drop_acc_we_low", we_low, 4);
    check("drop_acc_doe", doe_cnt, 8);
    check("drop_acc_ack", ack_cnt, 0);
    check("drop_acc_stall", stall_end, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
